// File: rtl/song_sequencer.sv
// Song playback sequencer: latches a song code, walks its note table
// one beat per note and flags completion back to the menu FSM.
module song_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000,
  parameter int MAX_LEN     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] song_confirm,
  input  logic [1:0] state,
  output logic [3:0] note,
  output logic       note_valid,
  output logic [4:0] note_idx,
  output logic       playing,
  output logic       finish
);

  localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0] SOUND_END = CW'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [4:0] IDX_LAST = 5'(MAX_LEN - 1);

  // Entry i lives in bits [4*i +: 4]; 4'hF marks end of song.
  localparam logic [63:0] SONG1 = 64'hFFFF_FFFF_8765_4321;
  localparam logic [63:0] SONG2 = 64'hFFFF_3344_0566_5511;
  localparam logic [63:0] SONG3 = 64'h0553_0222_0333_2123;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t          fsm;
  logic [1:0]    song;
  logic          started;
  logic [CW-1:0] beat_cnt;
  logic [4:0]    nxt_idx;
  logic [3:0]    nxt_note;
  logic          last;
  logic [3:0]    first_note;

  function automatic logic [3:0] tbl(input logic [1:0] s,
                                     input logic [4:0] i);
    logic [63:0] w;
    case (s)
      2'd1:    w = SONG1;
      2'd2:    w = SONG2;
      2'd3:    w = SONG3;
      default: w = '1;
    endcase
    return w[i[3:0]*4 +: 4];
  endfunction

  always_comb begin
    nxt_idx    = note_idx + 5'd1;
    nxt_note   = tbl(song, nxt_idx);
    last       = (nxt_note == 4'hF) || (note_idx == IDX_LAST);
    first_note = tbl(song_confirm, 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      song       <= 2'd0;
      started    <= 1'b0;
      beat_cnt   <= '0;
      note       <= 4'd0;
      note_valid <= 1'b0;
      note_idx   <= 5'd0;
      playing    <= 1'b0;
      finish     <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (song_confirm != 2'd0) begin
            fsm        <= RUN;
            song       <= song_confirm;
            started    <= 1'b0;
            beat_cnt   <= '0;
            note_idx   <= 5'd0;
            note       <= first_note;
            note_valid <= (first_note != 4'd0);
            playing    <= 1'b1;
          end
        end
        RUN: begin
          // Menu FSM lags one cycle entering PLAY, hence the started gate.
          if (started && state != 2'd2) begin
            fsm        <= IDLE;
            started    <= 1'b0;
            beat_cnt   <= '0;
            note       <= 4'd0;
            note_valid <= 1'b0;
            note_idx   <= 5'd0;
            playing    <= 1'b0;
            finish     <= 1'b0;
          end else begin
            started <= 1'b1;
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              if (last) begin
                fsm        <= DONE;
                started    <= 1'b0;
                note       <= 4'd0;
                note_valid <= 1'b0;
                playing    <= 1'b0;
                finish     <= 1'b1;
              end else begin
                note_idx   <= nxt_idx;
                note       <= nxt_note;
                note_valid <= (nxt_note != 4'd0);
              end
            end else begin
              beat_cnt   <= beat_cnt + 1'b1;
              note_valid <= (note != 4'd0) &&
                            ((beat_cnt + 1'b1) < SOUND_END);
            end
          end
        end
        DONE: begin
          if (state == 2'd3 || state == 2'd0) begin
            fsm    <= IDLE;
            finish <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
